// File: rtl/addsub_accumulator.sv
// Add/subtract accumulator with a ready/valid handshake.
// Accepts one command, computes it on the next cycle and holds the result until it is consumed.
module addsub_accumulator #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_m,
    input  logic             in_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] acc,
    output logic             carry,
    output logic             ovf,
    output logic             sticky_ovf,
    output logic [7:0]       op_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] y_q;
    logic             m_q, clr_q;
    logic [WIDTH-1:0] acc_q;
    logic             carry_q, ovf_q, sticky_q;
    logic [7:0]       cnt_q;

    logic [WIDTH-1:0] x, yx;
    logic [WIDTH:0]   sum_full;
    logic [WIDTH-1:0] sum_low;
    logic             ovf_d;

    // sum_low exposes the carry into the MSB (carry-out of bit WIDTH-2).
    always_comb begin
        x        = clr_q ? '0 : acc_q;
        yx       = y_q ^ {WIDTH{m_q}};
        sum_full = {1'b0, x} + {1'b0, yx} + {{WIDTH{1'b0}}, m_q};
        sum_low  = {1'b0, x[WIDTH-2:0]} + {1'b0, yx[WIDTH-2:0]}
                 + {{(WIDTH-1){1'b0}}, m_q};
        ovf_d    = sum_full[WIDTH] ^ sum_low[WIDTH-1];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = EXEC;
            EXEC:    state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            y_q      <= '0;
            m_q      <= 1'b0;
            clr_q    <= 1'b0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && in_valid) begin
                y_q   <= in_data;
                m_q   <= in_m;
                clr_q <= in_clr;
            end
            if (state_q == EXEC) begin
                acc_q    <= sum_full[WIDTH-1:0];
                carry_q  <= sum_full[WIDTH];
                ovf_q    <= ovf_d;
                sticky_q <= clr_q ? ovf_d : (sticky_q | ovf_d);
                cnt_q    <= cnt_q + 8'd1;
            end
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == HOLD);
    assign acc        = acc_q;
    assign carry      = carry_q;
    assign ovf        = ovf_q;
    assign sticky_ovf = sticky_q;
    assign op_count   = cnt_q;

endmodule

// File: tb/tb_addsub_accumulator.sv
// Directed bench for addsub_accumulator (WIDTH=4) with hand-computed expectations.
module tb_addsub_accumulator;

    logic       clk = 1'b0;
    logic       rst_n, in_valid, in_m, in_clr, out_ready;
    logic [3:0] in_data;
    logic       in_ready, out_valid, carry, ovf, sticky_ovf;
    logic [3:0] acc;
    logic [7:0] op_count;

    int tests = 0;
    int fails = 0;

    addsub_accumulator #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_m(in_m), .in_clr(in_clr),
        .out_valid(out_valid), .out_ready(out_ready),
        .acc(acc), .carry(carry), .ovf(ovf),
        .sticky_ovf(sticky_ovf), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Drive one command from IDLE and wait (bounded) until the result is in HOLD.
    task automatic issue(input logic [3:0] d, input logic m, input logic c);
        bit got;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_m = m; in_clr = c;
        @(posedge clk); #1;
        in_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 5 && !got; i++) begin
            @(posedge clk); #1;
            if (out_valid) got = 1'b1;
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL issue_timeout: out_valid never rose for data=%b m=%b clr=%b", d, m, c);
        end
    endtask

    task automatic release_hold();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if ({acc, carry, ovf, sticky_ovf, op_count} !== 15'd0) begin
            fails++;
            $display("FAIL reset_outputs: acc=%b c=%b v=%b s=%b cnt=%0d, want all 0",
                     acc, carry, ovf, sticky_ovf, op_count);
        end
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_add();
        issue(4'b0001, 1'b0, 1'b1);
        tests++;
        if ({acc, carry, ovf, op_count} !== {4'b0001, 1'b0, 1'b0, 8'd1}) begin
            fails++;
            $display("FAIL add_load: acc=%b c=%b v=%b cnt=%0d, want 0001 0 0 1", acc, carry, ovf, op_count);
        end
        release_hold();
        issue(4'b1010, 1'b0, 1'b0);
        tests++;
        if ({acc, carry, ovf, sticky_ovf, op_count} !== {4'b1011, 1'b0, 1'b0, 1'b0, 8'd2}) begin
            fails++;
            $display("FAIL add_acc: acc=%b c=%b v=%b s=%b cnt=%0d, want 1011 0 0 0 2",
                     acc, carry, ovf, sticky_ovf, op_count);
        end
        release_hold();
    endtask

    task automatic test_overflow();
        issue(4'b0111, 1'b0, 1'b1);
        release_hold();
        issue(4'b0001, 1'b0, 1'b0);
        tests++;
        if ({acc, carry, ovf, sticky_ovf, op_count} !== {4'b1000, 1'b0, 1'b1, 1'b1, 8'd4}) begin
            fails++;
            $display("FAIL ovf_set: acc=%b c=%b v=%b s=%b cnt=%0d, want 1000 0 1 1 4",
                     acc, carry, ovf, sticky_ovf, op_count);
        end
        release_hold();
        issue(4'b0001, 1'b0, 1'b0);
        tests++;
        if ({acc, ovf, sticky_ovf} !== {4'b1001, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL ovf_sticky_hold: acc=%b v=%b s=%b, want 1001 0 1", acc, ovf, sticky_ovf);
        end
        release_hold();
        issue(4'b0000, 1'b0, 1'b1);
        tests++;
        if ({acc, ovf, sticky_ovf, op_count} !== {4'b0000, 1'b0, 1'b0, 8'd6}) begin
            fails++;
            $display("FAIL ovf_clr: acc=%b v=%b s=%b cnt=%0d, want 0000 0 0 6", acc, ovf, sticky_ovf, op_count);
        end
        release_hold();
    endtask

    task automatic test_sub();
        issue(4'b0001, 1'b0, 1'b1);
        release_hold();
        issue(4'b1010, 1'b1, 1'b0);
        tests++;
        if ({acc, carry, ovf, op_count} !== {4'b0111, 1'b0, 1'b0, 8'd8}) begin
            fails++;
            $display("FAIL sub_borrow: acc=%b c=%b v=%b cnt=%0d, want 0111 0 0 8", acc, carry, ovf, op_count);
        end
        release_hold();
        issue(4'b1011, 1'b0, 1'b1);
        release_hold();
        issue(4'b0101, 1'b1, 1'b0);
        tests++;
        if ({acc, carry, ovf, sticky_ovf, op_count} !== {4'b0110, 1'b1, 1'b1, 1'b1, 8'd10}) begin
            fails++;
            $display("FAIL sub_ovf: acc=%b c=%b v=%b s=%b cnt=%0d, want 0110 1 1 1 10",
                     acc, carry, ovf, sticky_ovf, op_count);
        end
        release_hold();
    endtask

    task automatic test_backpressure();
        issue(4'b0010, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b1; in_data = 4'b0111; in_m = 1'b0; in_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests++;
            if ({out_valid, in_ready, acc, sticky_ovf, op_count} !== {1'b1, 1'b0, 4'b0010, 1'b0, 8'd11}) begin
                fails++;
                $display("FAIL stall_hold[%0d]: ov=%b ir=%b acc=%b s=%b cnt=%0d, want 1 0 0010 0 11",
                         i, out_valid, in_ready, acc, sticky_ovf, op_count);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        tests++;
        if ({out_valid, in_ready, acc, op_count} !== {1'b0, 1'b1, 4'b0010, 8'd11}) begin
            fails++;
            $display("FAIL stall_release: ov=%b ir=%b acc=%b cnt=%0d, want 0 1 0010 11",
                     out_valid, in_ready, acc, op_count);
        end
        @(negedge clk);
        out_ready = 1'b0;
        @(posedge clk); #1;
        tests++;
        if ({in_ready, out_valid} !== 2'b00) begin
            fails++;
            $display("FAIL stall_accept: ir=%b ov=%b, want 0 0 (EXEC)", in_ready, out_valid);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        tests++;
        if ({out_valid, acc, carry, ovf, sticky_ovf, op_count} !== {1'b1, 4'b1001, 1'b0, 1'b1, 1'b1, 8'd12}) begin
            fails++;
            $display("FAIL stall_next: ov=%b acc=%b c=%b v=%b s=%b cnt=%0d, want 1 1001 0 1 1 12",
                     out_valid, acc, carry, ovf, sticky_ovf, op_count);
        end
        release_hold();
    endtask

    task automatic test_reset_exec();
        issue(4'b0011, 1'b0, 1'b1);
        release_hold();
        @(negedge clk);
        in_valid = 1'b1; in_data = 4'b0101; in_m = 1'b0; in_clr = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        tests++;
        if ({acc, op_count, out_valid, sticky_ovf} !== {4'b0000, 8'd0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL rst_exec: acc=%b cnt=%0d ov=%b s=%b, want 0000 0 0 0",
                     acc, op_count, out_valid, sticky_ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            tests++;
            if ({in_ready, out_valid, acc, op_count} !== {1'b1, 1'b0, 4'b0000, 8'd0}) begin
                fails++;
                $display("FAIL rst_exec_discard: ir=%b ov=%b acc=%b cnt=%0d, want 1 0 0000 0",
                         in_ready, out_valid, acc, op_count);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 255; i++) begin
            issue(4'b0001, 1'b0, 1'b0);
            release_hold();
        end
        tests++;
        if ({op_count, acc} !== {8'd255, 4'b1111}) begin
            fails++;
            $display("FAIL wrap_pre: cnt=%0d acc=%b, want 255 1111", op_count, acc);
        end
        issue(4'b0001, 1'b0, 1'b0);
        tests++;
        if ({op_count, acc, carry, ovf} !== {8'd0, 4'b0000, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL wrap: cnt=%0d acc=%b c=%b v=%b, want 0 0000 1 0", op_count, acc, carry, ovf);
        end
        release_hold();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_m = 1'b0; in_clr = 1'b0; out_ready = 1'b0;
        test_reset();
        test_add();
        test_overflow();
        test_sub();
        test_backpressure();
        test_reset_exec();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
